// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared round states, winner codes and sprite box sizes for the chase game
package game_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_START = 3'd0,
    ST_SPAWN      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_CAUGHT     = 3'd3,
    ST_TIMEOUT    = 3'd4,
    ST_GAME_OVER  = 3'd5
  } round_state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_TOM   = 2'b01,
    WIN_JERRY = 2'b10
  } winner_e;

  localparam int unsigned TOM_WIDTH    = 32;
  localparam int unsigned TOM_HEIGHT   = 32;
  localparam int unsigned JERRY_WIDTH  = 24;
  localparam int unsigned JERRY_HEIGHT = 24;

  localparam int COORD_W = 10;
  localparam int SUM_W   = COORD_W + 1;

  // Scores stop at 15 rather than wrapping back to 0
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/catch_detect.sv
// rtl/catch_detect.sv - registered strict-overlap test between two axis-aligned sprite boxes
module catch_detect
  import game_pkg::*;
#(
  parameter int unsigned A_WIDTH  = TOM_WIDTH,
  parameter int unsigned A_HEIGHT = TOM_HEIGHT,
  parameter int unsigned B_WIDTH  = JERRY_WIDTH,
  parameter int unsigned B_HEIGHT = JERRY_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  output logic               hit_q
);

  logic [SUM_W-1:0] a_x_end;
  logic [SUM_W-1:0] a_y_end;
  logic [SUM_W-1:0] b_x_end;
  logic [SUM_W-1:0] b_y_end;
  logic             hit_d;

  // Far edges carry an extra bit so a box at the screen border cannot wrap; strict < keeps touching edges apart
  always_comb begin
    a_x_end = {1'b0, a_x} + SUM_W'(A_WIDTH);
    a_y_end = {1'b0, a_y} + SUM_W'(A_HEIGHT);
    b_x_end = {1'b0, b_x} + SUM_W'(B_WIDTH);
    b_y_end = {1'b0, b_y} + SUM_W'(B_HEIGHT);
    hit_d   = ({1'b0, a_x} < b_x_end) && ({1'b0, b_x} < a_x_end) &&
              ({1'b0, a_y} < b_y_end) && ({1'b0, b_y} < a_y_end);
  end

  // One cycle of latency so the consumer sees a clean flop output
  always_ff @(posedge clk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round/score sequencer for the chase game; ROUND_TIMER_EN adds the per-round countdown
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 65_000_000,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned WIN_SCORE     = 3,
  parameter int unsigned HOLD_CYCLES   = 32_500_000,
  parameter int unsigned SPAWN_CYCLES  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [9:0]   tom_x,
  input  logic [9:0]   tom_y,
  input  logic [9:0]   jerry_x,
  input  logic [9:0]   jerry_y,
  output logic         players_reset,
  output logic         move_en,
  output logic [3:0]   tom_score,
  output logic [3:0]   jerry_score,
  output logic [6:0]   time_left,
  output logic [1:0]   winner,
  output logic [2:0]   round_state
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > SPAWN_CYCLES) ? HOLD_CYCLES : SPAWN_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  if (CLK_HZ < 1 || ROUND_SECONDS < 1 || ROUND_SECONDS > 127 || WIN_SCORE < 1 || WIN_SCORE > 15 ||
      HOLD_CYCLES < 1 || SPAWN_CYCLES < 1) begin : g_bad_params
    $error("game_round_ctrl: parameter out of range");
  end

  round_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tom_q, tom_d;
  logic [3:0]       jerry_q, jerry_d;
  winner_e          winner_q, winner_d;
  logic             players_reset_q, players_reset_d;
  logic             move_en_q, move_en_d;
  logic             catch_q;

`ifdef ROUND_TIMER_EN
  localparam int PRE_W = $clog2(CLK_HZ + 1);
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [6:0]       time_left_q, time_left_d;
  logic             tick;
`endif

  catch_detect #(
    .A_WIDTH  (TOM_WIDTH),
    .A_HEIGHT (TOM_HEIGHT),
    .B_WIDTH  (JERRY_WIDTH),
    .B_HEIGHT (JERRY_HEIGHT)
  ) u_catch (
    .clk   (clk),
    .rst   (rst),
    .a_x   (tom_x),
    .a_y   (tom_y),
    .b_x   (jerry_x),
    .b_y   (jerry_y),
    .hit_q (catch_q)
  );

  // Next-state, score and output decode; outputs follow the next state so they leave the flops aligned with it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tom_d    = tom_q;
    jerry_d  = jerry_q;
    winner_d = winner_q;
`ifdef ROUND_TIMER_EN
    presc_d     = presc_q;
    time_left_d = time_left_q;
    tick        = 1'b0;
`endif
    case (state_q)
      ST_WAIT_START, ST_GAME_OVER: begin
        if (start) begin
          tom_d    = 4'd0;
          jerry_d  = 4'd0;
          winner_d = WIN_NONE;
          cnt_d    = '0;
          state_d  = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
`ifdef ROUND_TIMER_EN
        time_left_d = 7'(ROUND_SECONDS);
`endif
        if (cnt_q == CNT_W'(SPAWN_CYCLES - 1)) begin
          cnt_d   = '0;
`ifdef ROUND_TIMER_EN
          presc_d = '0;
`endif
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PLAY: begin
`ifdef ROUND_TIMER_EN
        tick = (presc_q == PRE_W'(CLK_HZ - 1));
        if (tick) begin
          presc_d = '0;
          if (time_left_q != 7'd0) time_left_d = time_left_q - 7'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
`endif
        // A catch outranks the clock running out in the same cycle
        if (catch_q) begin
          tom_d   = sat_inc4(tom_q);
          cnt_d   = '0;
          state_d = ST_CAUGHT;
        end
`ifdef ROUND_TIMER_EN
        else if (tick && time_left_q <= 7'd1) begin
          jerry_d = sat_inc4(jerry_q);
          cnt_d   = '0;
          state_d = ST_TIMEOUT;
        end
`endif
      end
      ST_CAUGHT, ST_TIMEOUT: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          if (state_q == ST_CAUGHT && tom_q == 4'(WIN_SCORE)) begin
            winner_d = WIN_TOM;
            state_d  = ST_GAME_OVER;
          end else if (state_q == ST_TIMEOUT && jerry_q == 4'(WIN_SCORE)) begin
            winner_d = WIN_JERRY;
            state_d  = ST_GAME_OVER;
          end else begin
            state_d = ST_SPAWN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT_START;
    endcase
    players_reset_d = (state_d == ST_WAIT_START) || (state_d == ST_SPAWN);
    move_en_d       = (state_d == ST_PLAY);
  end

  // All controller state; reset abandons any round in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_WAIT_START;
      cnt_q           <= '0;
      tom_q           <= 4'd0;
      jerry_q         <= 4'd0;
      winner_q        <= WIN_NONE;
      players_reset_q <= 1'b1;
      move_en_q       <= 1'b0;
`ifdef ROUND_TIMER_EN
      presc_q         <= '0;
      time_left_q     <= 7'(ROUND_SECONDS);
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tom_q           <= tom_d;
      jerry_q         <= jerry_d;
      winner_q        <= winner_d;
      players_reset_q <= players_reset_d;
      move_en_q       <= move_en_d;
`ifdef ROUND_TIMER_EN
      presc_q         <= presc_d;
      time_left_q     <= time_left_d;
`endif
    end
  end

`ifdef ROUND_TIMER_EN
  assign time_left = time_left_q;
`else
  assign time_left = 7'd0;
`endif

  assign players_reset = players_reset_q;
  assign move_en       = move_en_q;
  assign tom_score     = tom_q;
  assign jerry_score   = jerry_q;
  assign winner        = winner_q;
  assign round_state   = state_q;

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 65_000_000: clk frequency, used to derive a 1 s tick.
REQ-002 SHALL have parameter ROUND_SECONDS, default 60: round length in seconds, range 1..127.
REQ-003 SHALL have parameter WIN_SCORE, default 3: points that end the game, range 1..15.
REQ-004 SHALL have parameter HOLD_CYCLES, default 32_500_000: freeze length after a round ends.
REQ-005 SHALL have parameter SPAWN_CYCLES, default 16: length of the players_reset pulse.
REQ-006 SHALL have ports, clock and reset first: clk in 1, system clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: start in 1, level, begins or restarts the game; tom_x, tom_y, jerry_x, jerry_y in 10 each, sprite top-left coordinates.
REQ-008 SHALL have ports: players_reset out 1, drives the movement controllers' reset input; move_en out 1, gates player inputs.
REQ-009 SHALL have ports: tom_score out 4; jerry_score out 4; time_left out 7 (seconds); winner out 2 (00 none, 01 Tom, 10 Jerry); round_state out 3.

Function
REQ-010 SHALL implement FSM states WAIT_START, SPAWN, PLAY, CAUGHT, TIMEOUT, GAME_OVER, with round_state carrying the encoding.
REQ-011 In WAIT_START, with start=1 it SHALL clear both scores and winner, then enter SPAWN on the next cycle.
REQ-012 SPAWN SHALL hold players_reset=1 and move_en=0 for exactly SPAWN_CYCLES cycles and load time_left=ROUND_SECONDS, then enter PLAY.
REQ-013 PLAY SHALL drive move_en=1 and players_reset=0.
REQ-014 Catch SHALL be asserted when the boxes overlap strictly: tom_x<jerry_x+JERRY_WIDTH, jerry_x<tom_x+TOM_WIDTH, tom_y<jerry_y+JERRY_HEIGHT, jerry_y<tom_y+TOM_HEIGHT.
REQ-015 Catch arithmetic SHALL use 11-bit unsigned sums with no wrap; touching edges SHALL NOT count as a catch.
REQ-016 The catch flag SHALL be registered: coordinates at cycle n produce the FSM reaction at cycle n+1.
REQ-017 On catch in PLAY, the FSM SHALL increment tom_score and enter CAUGHT.
REQ-018 In PLAY, a free-running prescaler SHALL pulse once per CLK_HZ cycles; each pulse SHALL decrement time_left, saturating at 0.
REQ-019 When time_left reaches 0 in PLAY, the FSM SHALL increment jerry_score and enter TIMEOUT.
REQ-020 If a catch and time_left reaching 0 occur in the same cycle, the catch SHALL win: Tom scores.
REQ-021 CAUGHT and TIMEOUT SHALL drive move_en=0 for HOLD_CYCLES cycles.
REQ-022 After the hold, if the incremented score equals WIN_SCORE, the FSM SHALL set winner and enter GAME_OVER; otherwise it SHALL enter SPAWN.
REQ-023 Scores SHALL saturate at 15.
REQ-024 GAME_OVER SHALL hold move_en=0 and keep scores and winner; start=1 SHALL re-enter WAIT_START-clear behaviour, and scores SHALL be cleared before SPAWN.
REQ-025 start asserted during SPAWN, PLAY, CAUGHT or TIMEOUT SHALL be ignored.
REQ-026 The prescaler SHALL reset to 0 on every entry to PLAY.

Reset
REQ-027 rst SHALL force state WAIT_START, players_reset=1, move_en=0, scores=0, winner=00, time_left=ROUND_SECONDS, and all counters to 0.
REQ-028 rst mid-round SHALL abandon the round with no score change retained.

Configuration
REQ-029 With macro ROUND_TIMER_EN defined, the timeout path per REQ-018 to REQ-020 SHALL be present.
REQ-030 Without ROUND_TIMER_EN, there SHALL be no prescaler, time_left SHALL be tied to 0, and PLAY SHALL end only on catch.

Structure
REQ-031 The state enum, winner encoding and TOM/JERRY width/height constants SHALL live in game_pkg.
REQ-032 The overlap comparator SHALL be sub-module catch_detect, combinational with a registered output, reusable by other collision users.

Verification (CLK_HZ=10, ROUND_SECONDS=3, HOLD_CYCLES=4, SPAWN_CYCLES=2, WIN_SCORE=2)
REQ-033 rst then start=1 -> players_reset high for 2 cycles after entering SPAWN, then move_en=1, time_left=3.
REQ-034 Overlapping coordinates in PLAY -> tom_score=1 one cycle later, move_en=0 for 4 cycles, then SPAWN.
REQ-035 Edge-touching boxes (tom_x=jerry_x+JERRY_WIDTH) -> no catch; the round times out after 30 PLAY cycles and jerry_score=1.
REQ-036 Catch in the same cycle time_left reaches 0 -> tom_score increments, jerry_score unchanged.
REQ-037 Two Tom catches -> winner=01 and GAME_OVER; start=1 -> scores 0, new SPAWN.
REQ-038 rst asserted mid-PLAY -> all outputs at reset values on the next cycle; build without ROUND_TIMER_EN -> no timeout after 100 cycles.
